l2_cache_maint_sequencer: RTL and testbench

L2_CACHE_MAINT_SEQUENCER -- requirements
Module: l2_cache_maint_sequencer

---
 rtl/l2_cache_maint_sequencer.sv | 125 ++++++++++++
 tb/tb_l2_cache_maint_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_maint_sequencer.sv
// rtl/l2_cache_maint_sequencer.sv - full-cache flush/invalidate walk sequencer feeding the L2 arbiter stage
module l2_cache_maint_sequencer #(
    parameter int NUM_SETS        = 256,
    parameter int NUM_WAYS        = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             start_op,
    input  logic             abort,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [SET_W-1:0] req_set,
    output logic [WAY_W-1:0] req_way,
    output logic             req_op,
    input  logic             cpl_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t           state;
    logic [SET_W-1:0] set_cnt;
    logic [WAY_W-1:0] way_cnt;
    logic [OUT_W-1:0] outstanding;
    logic             op_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;

    logic xfer;
    logic cpl_ok;
    logic last_xfer;
    logic drained;

    // abort gates the offer combinationally so no transfer slips through in the abort cycle
    assign req_valid = (state == S_ISSUE) && !abort && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign xfer      = req_valid && req_ready;
    assign cpl_ok    = cpl_valid && (outstanding != '0);
    assign last_xfer = xfer && (set_cnt == SET_W'(NUM_SETS - 1)) && (way_cnt == WAY_W'(NUM_WAYS - 1));
    assign drained   = (outstanding == '0) || ((outstanding == OUT_W'(1)) && cpl_ok);

    assign req_set = set_cnt;
    assign req_way = way_cnt;
    assign req_op  = op_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            set_cnt     <= '0;
            way_cnt     <= '0;
            outstanding <= '0;
            op_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (xfer && !cpl_ok) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (cpl_ok && !xfer) begin
                outstanding <= outstanding - OUT_W'(1);
            end

            // power-of-two geometry lets both counters wrap to zero after the last line
            if (xfer) begin
                way_cnt <= way_cnt + WAY_W'(1);
                if (way_cnt == WAY_W'(NUM_WAYS - 1)) begin
                    set_cnt <= set_cnt + SET_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= start_op;
                        set_cnt   <= '0;
                        way_cnt   <= '0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state     <= S_DRAIN;
                    end else if (last_xfer) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    cpl_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(cpl_valid && (outstanding == '0)));

endmodule

// File: tb/tb_l2_cache_maint_sequencer.sv
// tb/tb_l2_cache_maint_sequencer.sv - scoreboard bench for the L2 maintenance walk sequencer
module tb_l2_cache_maint_sequencer;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 2;
    localparam int MAX_OUT  = 2;
    localparam int SET_W    = 2;
    localparam int WAY_W    = 1;
    localparam int WALK_LAT = NUM_SETS * NUM_WAYS + 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             start_op;
    logic             abort;
    logic             req_valid;
    logic             req_ready;
    logic [SET_W-1:0] req_set;
    logic [WAY_W-1:0] req_way;
    logic             req_op;
    logic             cpl_valid;
    logic             busy;
    logic             done;
    logic             aborted;

    always #5 clk = ~clk;

    l2_cache_maint_sequencer #(
        .NUM_SETS        (NUM_SETS),
        .NUM_WAYS        (NUM_WAYS),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .start_op  (start_op),
        .abort     (abort),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .req_way   (req_way),
        .req_op    (req_op),
        .cpl_valid (cpl_valid),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    typedef struct packed {
        logic [SET_W-1:0] set;
        logic [WAY_W-1:0] way;
        logic             op;
    } xfer_t;

    xfer_t exp_q[$];

    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    start_cyc = 0;
    int    xfer_cnt  = 0;
    int    done_cnt  = 0;
    int    done_cyc  = 0;
    int    outst     = 0;
    int    cpl_mode  = 0;
    int    done_base = 0;
    bit    rand_ready = 1'b0;
    logic  done_aborted = 1'b0;
    logic  xfer_seen    = 1'b0;
    logic  stall_prev   = 1'b0;
    xfer_t prev_req     = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe the current cycle at the falling edge, then drive the next cycle just after the rising edge.
    task automatic tick();
        xfer_t got;
        @(negedge clk);
        if (reset_n) begin
            got = {req_set, req_way, req_op};
            if (stall_prev && req_valid)
                check_eq("stall_hold", 32'(got), 32'(prev_req));
            xfer_seen = req_valid && req_ready;
            if (xfer_seen) begin
                xfer_cnt++;
                outst++;
                if (exp_q.size() == 0)
                    check_eq("extra_xfer", 32'(exp_q.size()), 32'd1);
                else
                    check_eq("xfer_order", 32'(got), 32'(exp_q.pop_front()));
            end
            if (cpl_valid) outst--;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                done_aborted = aborted;
            end
            stall_prev = req_valid && !req_ready;
            prev_req   = got;
        end else begin
            xfer_seen  = 1'b0;
            stall_prev = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (cpl_mode == 1)      cpl_valid = xfer_seen;
        else if (cpl_mode == 2) cpl_valid = (outst > 0);
        if (rand_ready) req_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic start_walk(input logic op);
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
                exp_q.push_back({SET_W'(s), WAY_W'(w), op});
        xfer_cnt  = 0;
        done_base = done_cnt;
        start     = 1'b1;
        start_op  = op;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_seen", done_cnt, done_base + 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        start_op  = 1'b0;
        abort     = 1'b0;
        req_ready = 1'b0;
        cpl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({req_valid, req_set, req_way, req_op, busy, done, aborted}), 32'd0);
        reset_n = 1'b1;
        tick();

        // in-order flush walk, one completion per transfer on the following cycle
        req_ready = 1'b1;
        cpl_mode  = 1;
        start_walk(1'b0);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        wait_done(60);
        check_eq("basic_xfers", xfer_cnt, 32'd8);
        check_eq("basic_queue_empty", exp_q.size(), 32'd0);
        check_eq("basic_latency", done_cyc - start_cyc, WALK_LAT);
        check_eq("basic_aborted", 32'(done_aborted), 32'd0);
        check_eq("done_single_pulse", 32'(done), 32'd0);
        check_eq("busy_low_after_done", 32'(busy), 32'd0);

        // random arbiter back-pressure
        rand_ready = 1'b1;
        start_walk(1'b0);
        wait_done(300);
        rand_ready = 1'b0;
        req_ready  = 1'b1;
        check_eq("stall_xfers", xfer_cnt, 32'd8);
        check_eq("stall_queue_empty", exp_q.size(), 32'd0);
        check_eq("stall_aborted", 32'(done_aborted), 32'd0);

        // outstanding cap with completions withheld
        cpl_mode  = 0;
        cpl_valid = 1'b0;
        start_walk(1'b0);
        repeat (3) tick();
        check_eq("cap_xfers", xfer_cnt, 32'd2);
        check_eq("cap_valid_low", 32'(req_valid), 32'd0);
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        repeat (3) tick();
        check_eq("cap_one_more", xfer_cnt, 32'd3);
        cpl_valid = 1'b1;
        tick();
        tick();
        cpl_valid = 1'b0;
        repeat (2) tick();
        check_eq("cap_simul_unchanged", xfer_cnt, 32'd5);
        check_eq("cap_valid_low_again", 32'(req_valid), 32'd0);
        cpl_mode = 2;
        wait_done(100);
        cpl_mode  = 0;
        cpl_valid = 1'b0;
        check_eq("cap_total_xfers", xfer_cnt, 32'd8);
        check_eq("cap_queue_empty", exp_q.size(), 32'd0);

        // abort after the third transfer with two outstanding
        start_walk(1'b0);
        tick();
        tick();
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        tick();
        check_eq("abort_pre_xfers", xfer_cnt, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        check_eq("abort_no_xfer", xfer_cnt, 32'd3);
        check_eq("abort_no_done_yet", done_cnt, done_base);
        check_eq("abort_busy", 32'(busy), 32'd1);
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        repeat (2) tick();
        check_eq("abort_one_cpl_no_done", done_cnt, done_base);
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        wait_done(20);
        check_eq("abort_flag", 32'(done_aborted), 32'd1);
        check_eq("abort_flag_held", 32'(aborted), 32'd1);
        exp_q.delete();

        // start while busy is ignored, then reset mid-walk
        cpl_mode = 1;
        start_walk(1'b0);
        check_eq("abort_cleared_on_start", 32'(aborted), 32'd0);
        repeat (2) tick();
        start    = 1'b1;
        start_op = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("ignored_start_xfers", xfer_cnt, 32'd4);
        cpl_mode  = 0;
        cpl_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_eq("reset_mid_walk", 32'({req_valid, req_set, req_way, req_op, busy, done, aborted}), 32'd0);
        done_base = done_cnt;
        repeat (2) tick();
        exp_q.delete();
        outst   = 0;
        reset_n = 1'b1;
        tick();
        check_eq("no_done_on_reset", done_cnt, done_base);

        // fresh invalidate walk after reset
        cpl_mode = 1;
        start_walk(1'b1);
        wait_done(60);
        check_eq("restart_xfers", xfer_cnt, 32'd8);
        check_eq("restart_queue_empty", exp_q.size(), 32'd0);
        check_eq("restart_latency", done_cyc - start_cyc, WALK_LAT);
        check_eq("restart_aborted", 32'(done_aborted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
